// File: rtl/bridge_pkg.sv
// Shared types and constants for the CPU-to-device bus bridge.
// Holds the FSM state type, device address windows and interrupt widths.
package bridge_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DONE
    } state_e;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_DEV0,
        SEL_DEV1
    } sel_e;

    localparam logic [31:0] DEV0_BASE  = 32'h0000_7F00;
    localparam logic [31:0] DEV0_LIMIT = 32'h0000_7F0B;
    localparam logic [31:0] DEV1_BASE  = 32'h0000_7F10;
    localparam logic [31:0] DEV1_LIMIT = 32'h0000_7F1B;

    localparam int HWINT_W = 6;
    localparam int IRQ_W   = 2;

    // Word-aligned addresses inside a device window select it.
    function automatic sel_e decode(input logic [31:0] addr);
        sel_e sel;
        sel = SEL_NONE;
        if (addr[1:0] == 2'b00) begin
            if (addr >= DEV0_BASE && addr <= DEV0_LIMIT)
                sel = SEL_DEV0;
            else if (addr >= DEV1_BASE && addr <= DEV1_LIMIT)
                sel = SEL_DEV1;
        end
        return sel;
    endfunction

endpackage

// File: rtl/irq_sync.sv
// Parameterized-width two-flop synchronizer for level interrupts.
// Asynchronous active-low reset clears both stages.
module irq_sync #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/bus_bridge.sv
// CPU-to-device bus bridge: two word-mapped devices, fixed 2-cycle access.
// Define BUS_BRIDGE_ERR_EN to report stray accesses on cpu_err.
module bus_bridge
    import bridge_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               cpu_req,
    input  logic               cpu_we,
    input  logic [31:0]        cpu_addr,
    input  logic [31:0]        cpu_wdata,
    output logic               cpu_ready,
    output logic [31:0]        cpu_rdata,
    output logic               cpu_err,
    output logic [31:0]        dev_addr,
    output logic [31:0]        dev_wdata,
    output logic               dev0_we,
    output logic               dev1_we,
    input  logic [31:0]        dev0_rdata,
    input  logic [31:0]        dev1_rdata,
    input  logic               dev0_irq,
    input  logic               dev1_irq,
    output logic [HWINT_W-1:0] hwint
);

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    sel_e        sel;
    logic [IRQ_W-1:0] irq_s;

    assign sel = decode(addr_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (cpu_req) begin
                    addr_d  = cpu_addr;
                    wdata_d = cpu_wdata;
                    state_d = cpu_we ? S_WRITE : S_READ;
                end
            end
            S_WRITE: state_d = S_DONE;
            S_READ: begin
                state_d = S_DONE;
                unique case (sel)
                    SEL_DEV0: rdata_d = dev0_rdata;
                    SEL_DEV1: rdata_d = dev1_rdata;
                    default:  rdata_d = '0;
                endcase
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign cpu_ready = (state_q == S_DONE);
    assign cpu_rdata = rdata_q;
    assign dev_addr  = addr_q;
    assign dev_wdata = wdata_q;
    assign dev0_we   = (state_q == S_WRITE) && (sel == SEL_DEV0);
    assign dev1_we   = (state_q == S_WRITE) && (sel == SEL_DEV1);

`ifdef BUS_BRIDGE_ERR_EN
    assign cpu_err = (state_q == S_DONE) && (sel == SEL_NONE);
`else
    assign cpu_err = 1'b0;
`endif

    irq_sync #(
        .W(IRQ_W)
    ) u_irq_sync (
        .clk   (clk),
        .rst_n (reset),
        .d_i   ({dev1_irq, dev0_irq}),
        .q_o   (irq_s)
    );

    assign hwint = {{(HWINT_W-IRQ_W){1'b0}}, irq_s};

endmodule
